// File: rtl/fsquare.sv
// Pipelined IEEE-754 single-precision squarer, y = x1*x1, round-to-nearest-even.
// Optional FSQUARE_STATS_EN adds saturating result/exception counters.
module fsquare #(
  parameter int NSTAGE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic        enable_in,
  output logic        enable_out,
  output logic [31:0] y,
  output logic        exception
`ifdef FSQUARE_STATS_EN
  ,
  output logic [31:0] op_count,
  output logic [31:0] exc_count
`endif
);

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  logic [NSTAGE:0] vld_pipe;

  logic [7:0]  s1_ex;
  logic [23:0] s1_m;
  cls_t        s1_cls;

  logic [47:0]       s2_p;
  logic signed [9:0] s2_e;
  cls_t              s2_cls;

  logic [23:0]       n_mant;
  logic              n_g, n_st;
  logic signed [9:0] n_e, e_fin;
  logic [24:0]       rnd;
  logic [31:0]       r_y;
  logic              r_exc;

  logic [31:0] dly_y   [2:NSTAGE-1];
  logic        dly_exc [2:NSTAGE-1];

  // Sign never reaches the result; the rounded leading one is implicit.
  logic unused_ok;
  assign unused_ok = x1[31] ^ rnd[23];

  assign enable_out = vld_pipe[NSTAGE];

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[NSTAGE-1:0], enable_in};
  end

  // Stage 1: unpack and classify; subnormals collapse to zero.
  always_ff @(posedge clk) begin
    s1_ex      <= x1[30:23];
    s1_m       <= {1'b1, x1[22:0]};
    s1_cls.nan  <= (&x1[30:23]) & (|x1[22:0]);
    s1_cls.inf  <= (&x1[30:23]) & ~(|x1[22:0]);
    s1_cls.zero <= ~(|x1[30:23]);
  end

  // Stage 2: full product and raw biased exponent 2*ex-127.
  always_ff @(posedge clk) begin
    s2_p   <= s1_m * s1_m;
    s2_e   <= $signed({1'b0, s1_ex, 1'b0}) - 10'sd127;
    s2_cls <= s1_cls;
  end

  // Stage 3: normalize, RNE round, renormalize on carry, then specials.
  always_comb begin
    if (s2_p[47]) begin
      n_mant = s2_p[47:24];
      n_g    = s2_p[23];
      n_st   = |s2_p[22:0];
      n_e    = s2_e + 10'sd1;
    end else begin
      n_mant = s2_p[46:23];
      n_g    = s2_p[22];
      n_st   = |s2_p[21:0];
      n_e    = s2_e;
    end
    rnd   = {1'b0, n_mant} + {24'h0, n_g & (n_st | n_mant[0])};
    e_fin = rnd[24] ? n_e + 10'sd1 : n_e;
    r_exc = 1'b0;
    r_y   = {1'b0, e_fin[7:0], rnd[24] ? 23'h0 : rnd[22:0]};
    if (s2_cls.nan) begin
      r_y   = 32'h7FC00000;
      r_exc = 1'b1;
    end else if (s2_cls.inf) begin
      r_y = 32'h7F800000;
    end else if (s2_cls.zero) begin
      r_y = 32'h0;
    end else if (e_fin >= 10'sd255) begin
      r_y   = 32'h7F800000;
      r_exc = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      r_y = 32'h0;
    end
  end

  // Stage 3 register followed by NSTAGE-3 pure delay registers.
  always_ff @(posedge clk) begin
    dly_y[2]   <= r_y;
    dly_exc[2] <= r_exc;
    for (int i = 3; i < NSTAGE; i++) begin
      dly_y[i]   <= dly_y[i-1];
      dly_exc[i] <= dly_exc[i-1];
    end
  end

  // Output registers only move when a valid result leaves the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= 32'h0;
      exception <= 1'b0;
    end else if (vld_pipe[NSTAGE-1]) begin
      y         <= dly_y[NSTAGE-1];
      exception <= dly_exc[NSTAGE-1];
    end
  end

`ifdef FSQUARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= 32'h0;
      exc_count <= 32'h0;
    end else if (vld_pipe[NSTAGE-1]) begin
      if (op_count != 32'hFFFFFFFF) op_count <= op_count + 32'd1;
      if (dly_exc[NSTAGE-1] && exc_count != 32'hFFFFFFFF)
        exc_count <= exc_count + 32'd1;
    end
  end
`endif

endmodule
